// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute controller for the 8-bit accumulator CPU.
// Fetches opcodes (and LDI/JMP operand bytes) over a req/ack port, holds the
// opcode in ir for the external decoder, and turns decoder enables into
// one-cycle execute strobes. Strobes, request and pulses are registered.
module instr_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int RST_VECTOR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [7:0]            imem_data,
  input  logic                  imem_ack,
  output logic [7:0]            ir,
  input  logic                  dec_rst,
  input  logic                  dec_ldi,
  input  logic                  dec_rf_en,
  input  logic                  dec_acu_en,
  input  logic                  dec_jmp_en,
  input  logic                  dec_r_or_w,
  output logic [7:0]            imm,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  rf_en_o,
  output logic                  acu_en_o,
  output logic                  r_or_w_o,
  output logic                  ldi_o,
  output logic                  retire,
  output logic                  illegal
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    OPER   = 2'd2,
    EXEC   = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RST_VECTOR);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
  localparam logic [7:0]            NOP_OP = 8'd12;

  // Opcodes above 31 are outside the instruction set.
  function automatic logic is_illegal(input logic [7:0] op);
    return (op[7:5] != 3'b000);
  endfunction

  state_t                state_r, next_state_s;
  logic [ADDR_WIDTH-1:0] pc_r, pc_next_s;
  logic [7:0]            ir_r, imm_r;
  logic                  req_r, rf_r, acu_r, rw_r, ldi_r, retire_r, illegal_r;
  logic                  acc_s;
  logic                  strobe_s;

  // An ack counts only while a request is actually being driven.
  assign acc_s = req_r & imem_ack;

  // Leaving for EXEC from a legal opcode arms the decoder-driven strobes.
  assign strobe_s = (next_state_s == EXEC) && !is_illegal(ir_r);

  // Next-state and next-pc selection.
  always_comb begin
    next_state_s = state_r;
    pc_next_s    = pc_r;
    case (state_r)
      FETCH: begin
        if (acc_s) begin
          next_state_s = DECODE;
          pc_next_s    = pc_r + PC_ONE;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: begin
        if (is_illegal(ir_r)) begin
          next_state_s = EXEC;
        end else if (dec_rst) begin
          next_state_s = FETCH;
          pc_next_s    = RST_PC;
        end else if (dec_ldi || dec_jmp_en) begin
          next_state_s = OPER;
        end else begin
          next_state_s = EXEC;
        end
      end
      OPER: begin
        if (acc_s) begin
          next_state_s = EXEC;
          if (dec_jmp_en) begin
            pc_next_s = imem_data[ADDR_WIDTH-1:0];
          end else begin
            pc_next_s = pc_r + PC_ONE;
          end
        end else begin
          next_state_s = OPER;
        end
      end
      EXEC: begin
        next_state_s = FETCH;
      end
      default: begin
        next_state_s = FETCH;
      end
    endcase
  end

  // State and program counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH;
      pc_r    <= RST_PC;
    end else begin
      state_r <= next_state_s;
      pc_r    <= pc_next_s;
    end
  end

  // Instruction and operand capture, only on accepted acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_r  <= NOP_OP;
      imm_r <= 8'd0;
    end else begin
      if (state_r == FETCH && acc_s) begin
        ir_r <= imem_data;
      end
      if (state_r == OPER && acc_s) begin
        imm_r <= imem_data;
      end
    end
  end

  // Registered request, execute strobes and retire/illegal pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r     <= 1'b0;
      rf_r      <= 1'b0;
      acu_r     <= 1'b0;
      rw_r      <= 1'b0;
      ldi_r     <= 1'b0;
      retire_r  <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      req_r     <= (next_state_s == FETCH) || (next_state_s == OPER);
      rf_r      <= strobe_s & dec_rf_en;
      acu_r     <= strobe_s & dec_acu_en;
      rw_r      <= strobe_s & dec_r_or_w;
      ldi_r     <= strobe_s & dec_ldi;
      retire_r  <= (next_state_s == EXEC);
      illegal_r <= (state_r == FETCH) && acc_s && is_illegal(imem_data);
    end
  end

  assign imem_req  = req_r;
  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign ir        = ir_r;
  assign imm       = imm_r;
  assign rf_en_o   = rf_r;
  assign acu_en_o  = acu_r;
  assign r_or_w_o  = rw_r;
  assign ldi_o     = ldi_r;
  assign retire    = retire_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a small opcode decoder model, a memory responder
// with per-address wait states, a cycle-by-cycle table for a program run, and
// hand-written sequences for wait states, spurious acks and mid-wait reset.
module tb_instr_sequencer;

  typedef struct packed {
    logic       req;
    logic [7:0] addr;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] imm;
    logic       rf;
    logic       acu;
    logic       rw;
    logic       ldi;
    logic       ret;
    logic       ill;
  } obs_t;

  typedef struct {
    logic ack_en;
    obs_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_req, imem_ack = 1'b0;
  logic [7:0] imem_addr, imem_data = 8'd0;
  logic [7:0] ir, imm, pc;
  logic       dec_rst, dec_ldi, dec_rf_en, dec_acu_en, dec_jmp_en, dec_r_or_w;
  logic       rf_en_o, acu_en_o, r_or_w_o, ldi_o, retire, illegal;

  logic [7:0] mem [256];
  logic       hold = 1'b0;
  logic       spur = 1'b0;
  int         cnt = 0;
  int         total = 0;
  int         bad = 0;
  vec_t       vt [20];
  obs_t       act;

  always #5 clk = ~clk;

  instr_sequencer #(.ADDR_WIDTH(8), .RST_VECTOR(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_ack(imem_ack),
    .ir(ir), .dec_rst(dec_rst), .dec_ldi(dec_ldi), .dec_rf_en(dec_rf_en),
    .dec_acu_en(dec_acu_en), .dec_jmp_en(dec_jmp_en), .dec_r_or_w(dec_r_or_w),
    .imm(imm), .pc(pc), .rf_en_o(rf_en_o), .acu_en_o(acu_en_o), .r_or_w_o(r_or_w_o),
    .ldi_o(ldi_o), .retire(retire), .illegal(illegal)
  );

  assign act = {imem_req, imem_addr, pc, ir, imm, rf_en_o, acu_en_o, r_or_w_o, ldi_o, retire, illegal};

  // Decoder model: ADD 0x05, ST 0x0B, NOP 0x0C, LDI 0x0D, JMP 0x0E, RST 0x10.
  always_comb begin
    dec_rst = 1'b0; dec_ldi = 1'b0; dec_rf_en = 1'b0;
    dec_acu_en = 1'b0; dec_jmp_en = 1'b0; dec_r_or_w = 1'b0;
    case (ir)
      8'h05: begin dec_rf_en = 1'b1; dec_acu_en = 1'b1; end
      8'h0B: begin dec_rf_en = 1'b1; dec_r_or_w = 1'b1; end
      8'h0D: begin dec_ldi = 1'b1; dec_acu_en = 1'b1; end
      8'h0E: dec_jmp_en = 1'b1;
      8'h10: dec_rst = 1'b1;
      default: ;
    endcase
  end

  // Memory responder: address 0xFF answers after 3 wait cycles, others at once.
  always @(negedge clk) begin
    if (imem_req && !hold) begin
      if (cnt >= ((imem_addr == 8'hFF) ? 3 : 0)) begin
        imem_ack = 1'b1; imem_data = mem[imem_addr]; cnt = 0;
      end else begin
        imem_ack = 1'b0; cnt = cnt + 1;
      end
    end else if (!imem_req && spur) begin
      imem_ack = 1'b1; imem_data = 8'h77; cnt = 0;
    end else begin
      imem_ack = 1'b0; cnt = 0;
    end
  end

  function automatic obs_t mk(input logic req, input logic [7:0] p, input logic [7:0] i,
                              input logic [7:0] m, input logic [5:0] f);
    obs_t o;
    o.req = req; o.addr = p; o.pc = p; o.ir = i; o.imm = m;
    {o.rf, o.acu, o.rw, o.ldi, o.ret, o.ill} = f;
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    total = total + 1;
    if (a !== e) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_state", 64'(act), 64'(mk(1'b0, 8'h00, 8'h0C, 8'h00, 6'b000000)));
  endtask

  initial begin
    // Program-run table; flags are {rf, acu, rw, ldi, retire, illegal}.
    vt[0]  = '{1'b1, mk(1'b1, 8'h00, 8'h0C, 8'h00, 6'b000000)};
    vt[1]  = '{1'b1, mk(1'b0, 8'h01, 8'h05, 8'h00, 6'b000000)};
    vt[2]  = '{1'b1, mk(1'b0, 8'h01, 8'h05, 8'h00, 6'b110010)};
    vt[3]  = '{1'b1, mk(1'b1, 8'h01, 8'h05, 8'h00, 6'b000000)};
    vt[4]  = '{1'b1, mk(1'b0, 8'h02, 8'h0D, 8'h00, 6'b000000)};
    vt[5]  = '{1'b1, mk(1'b1, 8'h02, 8'h0D, 8'h00, 6'b000000)};
    vt[6]  = '{1'b1, mk(1'b0, 8'h03, 8'h0D, 8'hA5, 6'b010110)};
    vt[7]  = '{1'b1, mk(1'b1, 8'h03, 8'h0D, 8'hA5, 6'b000000)};
    vt[8]  = '{1'b1, mk(1'b0, 8'h04, 8'h0E, 8'hA5, 6'b000000)};
    vt[9]  = '{1'b1, mk(1'b1, 8'h04, 8'h0E, 8'hA5, 6'b000000)};
    vt[10] = '{1'b1, mk(1'b0, 8'h40, 8'h0E, 8'h40, 6'b000010)};
    vt[11] = '{1'b1, mk(1'b1, 8'h40, 8'h0E, 8'h40, 6'b000000)};
    vt[12] = '{1'b1, mk(1'b0, 8'h41, 8'h40, 8'h40, 6'b000001)};
    vt[13] = '{1'b1, mk(1'b0, 8'h41, 8'h40, 8'h40, 6'b000010)};
    vt[14] = '{1'b1, mk(1'b1, 8'h41, 8'h40, 8'h40, 6'b000000)};
    vt[15] = '{1'b1, mk(1'b0, 8'h42, 8'h10, 8'h40, 6'b000000)};
    vt[16] = '{1'b1, mk(1'b1, 8'h00, 8'h10, 8'h40, 6'b000000)};
    vt[17] = '{1'b1, mk(1'b0, 8'h01, 8'h05, 8'h40, 6'b000000)};
    vt[18] = '{1'b1, mk(1'b0, 8'h01, 8'h05, 8'h40, 6'b110010)};
    vt[19] = '{1'b1, mk(1'b1, 8'h01, 8'h05, 8'h40, 6'b000000)};

    for (int a = 0; a < 256; a++) mem[a] = 8'h0C;
    mem[8'h00] = 8'h05; mem[8'h01] = 8'h0D; mem[8'h02] = 8'hA5;
    mem[8'h03] = 8'h0E; mem[8'h04] = 8'h40;
    mem[8'h40] = 8'h40; mem[8'h41] = 8'h10;

    do_reset();
    for (int i = 0; i < 20; i++) begin
      hold = !vt[i].ack_en;
      step();
      chk($sformatf("cycle_%0d", i + 1), 64'(act), 64'(vt[i].exp));
    end
    hold = 1'b0;

    // JMP to 0xFF, ST there with 3 wait cycles; spurious acks while idle.
    mem[8'h00] = 8'h0E; mem[8'h01] = 8'hFF; mem[8'hFF] = 8'h0B;
    spur = 1'b1;
    do_reset();
    step();
    chk("spur_ack_fetch_ir", 64'(ir), 64'(8'h0C));
    chk("first_req", 64'({imem_req, imem_addr}), 64'({1'b1, 8'h00}));
    step(); step(); step();
    chk("jmp_ff", 64'({pc, imm, retire, rf_en_o, acu_en_o}), 64'({8'hFF, 8'hFF, 3'b100}));
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("wait_req_%0d", k), 64'({imem_req, imem_addr}), 64'({1'b1, 8'hFF}));
    end
    step();
    chk("wrap_decode", 64'({imem_req, pc, ir}), 64'({1'b0, 8'h00, 8'h0B}));
    step();
    chk("st_exec", 64'({rf_en_o, r_or_w_o, acu_en_o, ldi_o, retire, ir}), 64'({5'b11001, 8'h0B}));
    spur = 1'b0;

    // Reset asserted during an OPER wait takes effect without a clock edge.
    mem[8'h00] = 8'h0D; mem[8'h01] = 8'h99;
    do_reset();
    step(); step();
    hold = 1'b1;
    step(); step(); step();
    chk("oper_wait", 64'({imem_req, imem_addr, pc, ir}), 64'({1'b1, 8'h01, 8'h01, 8'h0D}));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_abort", 64'(act), 64'(mk(1'b0, 8'h00, 8'h0C, 8'h00, 6'b000000)));
    hold = 1'b0;
    do_reset();
    step();
    chk("refetch_after_abort", 64'({imem_req, imem_addr}), 64'({1'b1, 8'h00}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
